// File: rtl/iterative_shift_unit.sv
// Multi-cycle RV32I shift unit (SLL/SRL/SRA): one power-of-two stage per clock,
// stopping as soon as no higher shift-amount bits remain.
module iterative_shift_unit #(
    parameter  int nb_bits_data  = 32,
    localparam int nb_bits_shamt = $clog2(nb_bits_data)
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     start_i,
    input  logic                     flush_i,
    input  logic [1:0]               op_i,
    input  logic [nb_bits_data-1:0]  data_i,
    input  logic [nb_bits_shamt-1:0] shamt_i,
    output logic                     ready_o,
    output logic                     busy_o,
    output logic                     valid_o,
    output logic [nb_bits_data-1:0]  result_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    state_t state, next_state;

    logic [nb_bits_data-1:0]  acc;
    logic [nb_bits_data-1:0]  shifted;
    logic [nb_bits_shamt-1:0] rem;
    logic [nb_bits_shamt-1:0] k;
    logic [nb_bits_shamt-1:0] stage_bit;
    logic [nb_bits_shamt-1:0] rem_cleared;
    logic [nb_bits_shamt:0]   stage_dist;
    logic [1:0]               op;
    logic                     accept;
    logic                     last_stage;

    assign accept = (state == IDLE) && start_i && !flush_i;

    // Stage k shifts by 2^k when rem[k] is set; lower rem bits are already
    // cleared, so an empty rem after clearing bit k means this is the last stage.
    always_comb begin
        stage_bit   = nb_bits_shamt'(1) << k;
        stage_dist  = (nb_bits_shamt + 1)'(1) << k;
        rem_cleared = rem & ~stage_bit;
        last_stage  = (rem_cleared == '0);
        shifted     = acc;
        if ((rem & stage_bit) != '0) begin
            case (op)
                2'b01:   shifted = acc >> stage_dist;
                2'b11:   shifted = $unsigned($signed(acc) >>> stage_dist);
                default: shifted = acc << stage_dist;
            endcase
        end
    end

    always_comb begin
        next_state = state;
        if (flush_i) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        next_state = (shamt_i != '0) ? SHIFT : DONE;
                    end
                end
                SHIFT: begin
                    if (last_stage) begin
                        next_state = DONE;
                    end
                end
                DONE:    next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A flushed operation never touches result_o, so the last good result survives.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            acc      <= '0;
            rem      <= '0;
            k        <= '0;
            op       <= 2'b00;
            result_o <= '0;
        end else if (accept) begin
            if (shamt_i != '0) begin
                acc <= data_i;
                rem <= shamt_i;
                op  <= op_i;
                k   <= '0;
            end else begin
                result_o <= data_i;
            end
        end else if ((state == SHIFT) && !flush_i) begin
            acc <= shifted;
            rem <= rem_cleared;
            k   <= k + nb_bits_shamt'(1);
            if (last_stage) begin
                result_o <= shifted;
            end
        end
    end

    assign ready_o = (state == IDLE);
    assign busy_o  = (state == SHIFT);
    assign valid_o = (state == DONE);

endmodule

// File: tb/tb_iterative_shift_unit.sv
// Self-checking bench for iterative_shift_unit: directed scenarios plus random
// back-to-back operations, with expected results queued at launch time.
module tb_iterative_shift_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        flush;
    logic [1:0]  op;
    logic [31:0] data;
    logic [4:0]  shamt;
    logic        ready_o;
    logic        busy_o;
    logic        valid_o;
    logic [31:0] result_o;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];

    iterative_shift_unit #(.nb_bits_data(32)) dut (
        .clk_i    (clk),
        .rst_n_i  (rst_n),
        .start_i  (start),
        .flush_i  (flush),
        .op_i     (op),
        .data_i   (data),
        .shamt_i  (shamt),
        .ready_o  (ready_o),
        .busy_o   (busy_o),
        .valid_o  (valid_o),
        .result_o (result_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] model_shift(input logic [31:0] d, input logic [4:0] s,
                                                input logic [1:0] o);
        case (o)
            2'b01:   return d >> s;
            2'b11:   return $unsigned($signed(d) >>> s);
            default: return d << s;
        endcase
    endfunction

    function automatic int model_latency(input logic [4:0] s);
        int h;
        h = -1;
        for (int i = 0; i < 5; i++) begin
            if (s[i]) h = i;
        end
        return (h < 0) ? 1 : h + 2;
    endfunction

    // Caller is at a negedge (cycle 0); returns at the negedge of cycle 1.
    task automatic launch(input logic [31:0] d, input logic [4:0] s, input logic [1:0] o,
                          input bit expect_result);
        data  = d;
        shamt = s;
        op    = o;
        start = 1'b1;
        if (expect_result) exp_q.push_back(model_shift(d, s, o));
        @(negedge clk);
        start = 1'b0;
        data  = $urandom;
        shamt = 5'($urandom);
        op    = 2'($urandom);
    endtask

    task automatic wait_valid(input int first_cyc, output int cyc, output bit busy_seen);
        cyc       = -1;
        busy_seen = 1'b0;
        for (int c = first_cyc; c < first_cyc + 20; c++) begin
            if (c != first_cyc) @(negedge clk);
            if (busy_o) busy_seen = 1'b1;
            if (valid_o) begin
                cyc = c;
                break;
            end
        end
    endtask

    task automatic test_reset;
        start = 1'b0;
        flush = 1'b0;
        op    = 2'b00;
        data  = '0;
        shamt = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #11;
        checks++;
        if ({ready_o, busy_o, valid_o} !== 3'b100) begin
            errors++;
            $display("[TB] FAIL reset_flags got %b want 100", {ready_o, busy_o, valid_o});
        end
        checks++;
        if (result_o !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_result got %h want 00000000", result_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_sll_max;
        logic [31:0] exp;
        launch(32'h0000_0001, 5'd31, 2'b00, 1'b1);
        for (int c = 1; c <= 7; c++) begin
            if (c != 1) @(negedge clk);
            checks++;
            if ({ready_o, busy_o, valid_o} !== {c == 7, c <= 5, c == 6}) begin
                errors++;
                $display("[TB] FAIL sll_flags_c%0d got %b want %b", c,
                         {ready_o, busy_o, valid_o}, {c == 7, c <= 5, c == 6});
            end
            if (c == 6) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL sll_result got %h want <queue empty>", result_o);
                end else begin
                    exp = exp_q.pop_front();
                    if (result_o !== exp) begin
                        errors++;
                        $display("[TB] FAIL sll_result got %h want %h", result_o, exp);
                    end
                end
            end
        end
    endtask

    task automatic test_sra_srl;
        logic [31:0] exp;
        int          cyc;
        bit          busy_seen;
        logic [1:0]  ops[2] = '{2'b11, 2'b01};
        foreach (ops[i]) begin
            @(negedge clk);
            launch(32'h8000_0000, 5'd4, ops[i], 1'b1);
            wait_valid(1, cyc, busy_seen);
            checks++;
            if (cyc != 4) begin
                errors++;
                $display("[TB] FAIL shr_latency_op%b got %0d want 4", ops[i], cyc);
            end
            checks++;
            exp = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
            if (result_o !== exp) begin
                errors++;
                $display("[TB] FAIL shr_result_op%b got %h want %h", ops[i], result_o, exp);
            end
        end
    endtask

    task automatic test_zero_shift;
        logic [31:0] exp;
        int          cyc;
        bit          busy_seen;
        @(negedge clk);
        launch(32'hDEAD_BEEF, 5'd0, 2'b11, 1'b1);
        wait_valid(1, cyc, busy_seen);
        checks++;
        if (cyc != 1 || busy_seen) begin
            errors++;
            $display("[TB] FAIL zero_latency got %0d busy %0b want 1 busy 0", cyc, busy_seen);
        end
        checks++;
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
        if (result_o !== exp) begin
            errors++;
            $display("[TB] FAIL zero_result got %h want %h", result_o, exp);
        end
    endtask

    task automatic test_ignored_start;
        logic [31:0] exp;
        int          cyc;
        int          extra;
        bit          busy_seen;
        @(negedge clk);
        launch(32'h0000_FFFF, 5'd16, 2'b00, 1'b1);
        start = 1'b1;
        data  = 32'h0000_0003;
        shamt = 5'd1;
        op    = 2'b01;
        @(negedge clk);
        start = 1'b0;
        wait_valid(2, cyc, busy_seen);
        checks++;
        if (cyc != 6) begin
            errors++;
            $display("[TB] FAIL ign_latency got %0d want 6", cyc);
        end
        checks++;
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
        if (result_o !== exp) begin
            errors++;
            $display("[TB] FAIL ign_result got %h want %h", result_o, exp);
        end
        @(negedge clk);
        checks++;
        if ({ready_o, valid_o} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL ign_ready_after got %b want 10", {ready_o, valid_o});
        end
        launch(32'h0000_00F0, 5'd4, 2'b01, 1'b1);
        wait_valid(1, cyc, busy_seen);
        checks++;
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
        if (cyc != 4 || result_o !== exp) begin
            errors++;
            $display("[TB] FAIL ign_next_op got cyc %0d %h want cyc 4 %h", cyc, result_o, exp);
        end
        extra = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (valid_o) extra++;
        end
        checks++;
        if (extra != 0) begin
            errors++;
            $display("[TB] FAIL ign_extra_valid got %0d want 0", extra);
        end
    endtask

    task automatic test_flush;
        logic [31:0] exp;
        int          cyc;
        int          extra;
        bit          busy_seen;
        @(negedge clk);
        launch(32'h1234_5678, 5'd0, 2'b00, 1'b1);
        wait_valid(1, cyc, busy_seen);
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
        checks++;
        if (result_o !== exp) begin
            errors++;
            $display("[TB] FAIL flush_setup got %h want %h", result_o, exp);
        end
        @(negedge clk);
        launch(32'hFFFF_FFFF, 5'd24, 2'b00, 1'b0);
        @(negedge clk);
        flush = 1'b1;
        start = 1'b1;
        @(negedge clk);
        checks++;
        if ({ready_o, busy_o, valid_o} !== 3'b100) begin
            errors++;
            $display("[TB] FAIL flush_shift_flags got %b want 100", {ready_o, busy_o, valid_o});
        end
        @(negedge clk);
        flush = 1'b0;
        start = 1'b0;
        checks++;
        if ({ready_o, busy_o, valid_o} !== 3'b100) begin
            errors++;
            $display("[TB] FAIL flush_idle_start got %b want 100", {ready_o, busy_o, valid_o});
        end
        extra = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (valid_o) extra++;
        end
        checks++;
        if (extra != 0 || result_o !== 32'h1234_5678) begin
            errors++;
            $display("[TB] FAIL flush_discard got valids %0d %h want 0 12345678", extra, result_o);
        end
        launch(32'hCAFE_0001, 5'd0, 2'b00, 1'b1);
        flush = 1'b1;
        checks++;
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
        if (valid_o !== 1'b1 || result_o !== exp) begin
            errors++;
            $display("[TB] FAIL flush_done got valid %b %h want 1 %h", valid_o, result_o, exp);
        end
        @(negedge clk);
        flush = 1'b0;
        checks++;
        if ({ready_o, busy_o, valid_o} !== 3'b100) begin
            errors++;
            $display("[TB] FAIL flush_done_after got %b want 100", {ready_o, busy_o, valid_o});
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] exp;
        int          cyc;
        int          extra;
        bit          busy_seen;
        @(negedge clk);
        launch(32'h0000_0001, 5'd31, 2'b00, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({ready_o, busy_o, valid_o} !== 3'b100 || result_o !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_mid got %b %h want 100 00000000",
                     {ready_o, busy_o, valid_o}, result_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        extra = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (valid_o) extra++;
        end
        checks++;
        if (extra != 0) begin
            errors++;
            $display("[TB] FAIL reset_mid_pending got %0d want 0", extra);
        end
        launch(32'hFFFF_FFFF, 5'd1, 2'b01, 1'b1);
        wait_valid(1, cyc, busy_seen);
        checks++;
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
        if (cyc != 2 || result_o !== exp) begin
            errors++;
            $display("[TB] FAIL reset_mid_next got cyc %0d %h want cyc 2 %h", cyc, result_o, exp);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] exp;
        logic [31:0] d;
        logic [4:0]  s;
        logic [1:0]  o;
        int          cyc;
        bit          busy_seen;
        for (int i = 0; i < 24; i++) begin
            d = $urandom;
            s = 5'($urandom);
            o = 2'($urandom);
            @(negedge clk);
            checks++;
            if (ready_o !== 1'b1) begin
                errors++;
                $display("[TB] FAIL b2b_ready_%0d got %b want 1", i, ready_o);
            end
            launch(d, s, o, 1'b1);
            wait_valid(1, cyc, busy_seen);
            checks++;
            if (cyc != model_latency(s)) begin
                errors++;
                $display("[TB] FAIL b2b_latency_%0d shamt %0d got %0d want %0d", i, s, cyc,
                         model_latency(s));
            end
            checks++;
            exp = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
            if (result_o !== exp) begin
                errors++;
                $display("[TB] FAIL b2b_result_%0d op %b d %h s %0d got %h want %h", i, o, d, s,
                         result_o, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_sll_max();
        test_sra_srl();
        test_zero_shift();
        test_ignored_start();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain got %0d want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/iterative_shift_unit.md
Name: iterative_shift_unit

Overview:
Multi-cycle RV32I shift unit for SLL, SRL and SRA. It sequences one fixed power-of-two shift stage per clock (1, 2, 4, 8, 16), enabled by the matching shift-amount bit, and exits early once no higher shift-amount bits remain. It sits beside the ALU in the execute stage as a low-area alternative to a full barrel shifter, and uses a start/valid handshake with the pipeline control.

Parameters:
nb_bits_data, 32, operand/result width; must be a power of two, minimum 2
nb_bits_shamt, $clog2(nb_bits_data), shift-amount width (derived; do not override)

Ports:
clk_i  input  1  system clock, rising edge
rst_n_i  input  1  reset, asynchronous, active-low
start_i  input  1  request a shift; accepted only when ready_o=1
flush_i  input  1  synchronous abort, from the pipeline flush
op_i  input  2  00=SLL, 01=SRL, 11=SRA, 10=reserved (executes as SLL)
data_i  input  nb_bits_data  operand, sampled on accept
shamt_i  input  nb_bits_shamt  shift amount, sampled on accept
ready_o  output  1  unit idle, can accept start_i
busy_o  output  1  operation in progress (state SHIFT)
valid_o  output  1  one-cycle pulse: result_o holds a new result
result_o  output  nb_bits_data  last completed result; held until the next completion

Behaviour:
- Reset: rst_n_i=0 forces, asynchronously, state=IDLE, acc=0, rem=0, k=0, result_o=0, valid_o=0, busy_o=0, ready_o=1.
- Registers: acc (nb_bits_data), rem (nb_bits_shamt), k (stage index), op, result_o. ready_o, busy_o and valid_o decode from state only.
- State IDLE: ready_o=1. Accept = start_i & ~flush_i.
  - On accept with shamt_i != 0: acc<=data_i, rem<=shamt_i, op<=op_i, k<=0, go to SHIFT.
  - On accept with shamt_i == 0: result_o<=data_i, go to DONE.
- State SHIFT: busy_o=1. Each cycle:
  - If rem[k]=1, acc <= acc shifted by 2^k. SLL fills with zeros. SRL fills with zeros. SRA fills with acc[MSB].
  - rem[k]<=0 and k<=k+1.
  - If rem has no set bits above position k: result_o <= the shifted value and go to DONE. Otherwise stay in SHIFT.
- State DONE: valid_o=1 for exactly one cycle, then go to IDLE unconditionally. ready_o=0 in DONE.
- Latency: start accepted at cycle 0. valid_o is high in cycle h+2, where h is the index of the highest set bit of shamt. For shamt=0, valid_o is high in cycle 1. Worst case (shamt bit 4 set) is valid_o in cycle 6.
- A new start can be accepted at the earliest in the cycle after valid_o. Throughput is one operation per h+3 cycles.
- start_i outside IDLE is ignored, not queued. data_i and shamt_i are don't-care when no accept occurs.
- flush_i has priority over everything except reset. In any state it forces IDLE on the next edge.
  - Flush in SHIFT: the operation is discarded, no valid_o, result_o keeps its previous value.
  - Flush in DONE: the valid_o pulse of that cycle still shows (it is combinational from DONE); the state then returns to IDLE.
  - start_i in the same cycle as flush_i is not accepted.
- Reset during SHIFT or DONE: immediate return to IDLE and all registers cleared; no valid_o is produced afterwards.
- op is latched at accept; changes on op_i mid-operation have no effect.
- The shifted result always has width nb_bits_data. Bits shifted out are lost; there is no wrap-around.

Test Plan:
- SLL: data=0x0000_0001, shamt=31, op=00 -> valid_o in cycle 6, result_o=0x8000_0000. busy_o high in cycles 1-5, ready_o low in cycles 1-6.
- SRA and SRL: data=0x8000_0000, shamt=4. op=11 -> result_o=0xF800_0000. op=01 -> result_o=0x0800_0000. valid_o in cycle 4 for both.
- Zero shift: data=0xDEAD_BEEF, shamt=0, op=11 -> valid_o in cycle 1, result_o=0xDEAD_BEEF, no busy_o.
- Ignored start: a second start_i is pulsed during SHIFT of a shamt=16 SLL on 0x0000_FFFF -> only one valid_o, result_o=0xFFFF_0000. A new start is accepted the cycle after valid_o.
- Flush: flush_i in cycle 2 of a shamt=24 op, with result_o=0x1234_5678 beforehand -> IDLE in cycle 3, no valid_o, result_o still 0x1234_5678. start_i driven with the flush is not accepted.
- Reset mid-operation: rst_n_i low asynchronously during SHIFT -> outputs at reset values immediately, with no pending valid_o after release. A back-to-back SRL of 0xFFFF_FFFF by 1 afterwards gives 0x7FFF_FFFF with valid_o in cycle 2.
